// File: rtl/probe_route_queue_if.sv
// probe_route_queue_if
//   Handshake and message bundle for probe_route_queue.
//   master : drives the arbiter-side message in, and the per-destination readies
//   slave  : the queue; drives io_in_ready, the four port valids, head bits, io_count
//   DEPTH  : must match the queue's DEPTH (sets io_count width)
interface probe_route_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          io_in_valid;
    logic          io_in_ready;
    logic [1:0]    io_in_bits_header_src;
    logic [1:0]    io_in_bits_header_dst;
    logic [25:0]   io_in_bits_payload_addr_block;
    logic [1:0]    io_in_bits_payload_p_type;

    logic          io_out_0_valid;
    logic          io_out_1_valid;
    logic          io_out_2_valid;
    logic          io_out_3_valid;
    logic          io_out_0_ready;
    logic          io_out_1_ready;
    logic          io_out_2_ready;
    logic          io_out_3_ready;
    logic [1:0]    io_out_bits_header_src;
    logic [1:0]    io_out_bits_header_dst;
    logic [25:0]   io_out_bits_payload_addr_block;
    logic [1:0]    io_out_bits_payload_p_type;

    logic [CW-1:0] io_count;

    modport master (
        output io_in_valid, io_in_bits_header_src, io_in_bits_header_dst,
               io_in_bits_payload_addr_block, io_in_bits_payload_p_type,
               io_out_0_ready, io_out_1_ready, io_out_2_ready, io_out_3_ready,
        input  io_in_ready, io_out_0_valid, io_out_1_valid, io_out_2_valid, io_out_3_valid,
               io_out_bits_header_src, io_out_bits_header_dst,
               io_out_bits_payload_addr_block, io_out_bits_payload_p_type, io_count
    );

    modport slave (
        input  io_in_valid, io_in_bits_header_src, io_in_bits_header_dst,
               io_in_bits_payload_addr_block, io_in_bits_payload_p_type,
               io_out_0_ready, io_out_1_ready, io_out_2_ready, io_out_3_ready,
        output io_in_ready, io_out_0_valid, io_out_1_valid, io_out_2_valid, io_out_3_valid,
               io_out_bits_header_src, io_out_bits_header_dst,
               io_out_bits_payload_addr_block, io_out_bits_payload_p_type, io_count
    );
endinterface

// File: rtl/probe_route_queue.sv
// probe_route_queue
//   DEPTH-entry FIFO behind the 4:1 probe arbiter. The head message is steered
//   to output port header_dst; a stalled head blocks everything behind it.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous active-high reset (clears pointers and occupancy)
//     q     : probe_route_queue_if.slave (input handshake, 4 output ports, io_count)
//   Parameter DEPTH : entries, power of two in 2..16 (default 4).
//   Macro PROBE_ROUTE_QUEUE_FLOW_EN : when defined, an empty queue presents the
//   incoming message combinationally and bypasses storage if the target port
//   accepts it the same cycle. Undefined: registered-only path, 1-cycle latency.
module probe_route_queue #(
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                reset,
    probe_route_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [1:0]  src;
        logic [1:0]  dst;
        logic [25:0] addr;
        logic [1:0]  p_type;
    } msg_t;

    msg_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    msg_t       in_msg;
    msg_t       head_msg;
    logic       empty;
    logic       in_ready;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       bypass;
    logic       enq;
    logic       deq;

    assign in_msg    = '{src:    q.io_in_bits_header_src,
                         dst:    q.io_in_bits_header_dst,
                         addr:   q.io_in_bits_payload_addr_block,
                         p_type: q.io_in_bits_payload_p_type};
    assign out_ready = {q.io_out_3_ready, q.io_out_2_ready, q.io_out_1_ready, q.io_out_0_ready};
    assign empty     = (count_q == '0);
    // Full depends only on stored occupancy; a same-cycle dequeue does not open a slot.
    assign in_ready  = (count_q != CW'(DEPTH));

    always_comb begin
        head_msg  = mem_q[rptr_q];
        out_valid = empty ? 4'b0000 : (4'b0001 << head_msg.dst);
        bypass    = 1'b0;
`ifdef PROBE_ROUTE_QUEUE_FLOW_EN
        if (empty && q.io_in_valid) begin
            head_msg  = in_msg;
            out_valid = 4'b0001 << in_msg.dst;
            bypass    = |(out_valid & out_ready);
        end
`endif
        // Only the selected port's ready matters: out_valid is one-hot.
        deq     = !empty && |(out_valid & out_ready);
        enq     = q.io_in_valid && in_ready && !bypass;
        wptr_d  = enq ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = deq ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared too so the head bits never read back as X once the
    // read pointer moves onto a slot that has not been written since reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (enq) mem_q[wptr_q] <= in_msg;
        end
    end

    assign q.io_in_ready                    = in_ready;
    assign q.io_out_0_valid                 = out_valid[0];
    assign q.io_out_1_valid                 = out_valid[1];
    assign q.io_out_2_valid                 = out_valid[2];
    assign q.io_out_3_valid                 = out_valid[3];
    assign q.io_out_bits_header_src         = head_msg.src;
    assign q.io_out_bits_header_dst         = head_msg.dst;
    assign q.io_out_bits_payload_addr_block = head_msg.addr;
    assign q.io_out_bits_payload_p_type     = head_msg.p_type;
    assign q.io_count                       = count_q;
endmodule

// File: tb/tb_probe_route_queue.sv
// tb_probe_route_queue
//   Directed bench for probe_route_queue (default build, DEPTH = 4).
//   A plain queue of messages models the FIFO; every falling edge the DUT
//   outputs are compared against it, and literal expectations pin key points.
module tb_probe_route_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_msg = '0;
    logic [3:0]  out_ready = 4'b0000;

    int tests = 0;
    int fails = 0;

    // Message word: {src[31:30], dst[29:28], addr[27:2], p_type[1:0]}
    logic [31:0] model[$];
    bit          m_enq, m_deq;

    probe_route_queue_if #(.DEPTH(DEPTH)) qif ();

    probe_route_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (qif)
    );

    assign qif.io_in_valid                   = in_valid;
    assign qif.io_in_bits_header_src         = in_msg[31:30];
    assign qif.io_in_bits_header_dst         = in_msg[29:28];
    assign qif.io_in_bits_payload_addr_block = in_msg[27:2];
    assign qif.io_in_bits_payload_p_type     = in_msg[1:0];
    assign qif.io_out_0_ready                = out_ready[0];
    assign qif.io_out_1_ready                = out_ready[1];
    assign qif.io_out_2_ready                = out_ready[2];
    assign qif.io_out_3_ready                = out_ready[3];

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [1:0] src, input logic [1:0] dst,
                                       input logic [25:0] addr, input logic [1:0] pt);
        return {src, dst, addr, pt};
    endfunction

    function automatic logic [3:0] dut_valid();
        return {qif.io_out_3_valid, qif.io_out_2_valid, qif.io_out_1_valid, qif.io_out_0_valid};
    endfunction

    function automatic logic [31:0] dut_bits();
        return {qif.io_out_bits_header_src, qif.io_out_bits_header_dst,
                qif.io_out_bits_payload_addr_block, qif.io_out_bits_payload_p_type};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference FIFO: accept while fewer than DEPTH held, release the head when
    // the port named by its destination is ready.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model.delete();
        end else begin
            m_enq = in_valid && (model.size() < DEPTH);
            m_deq = (model.size() > 0) && out_ready[model[0][29:28]];
            if (m_deq) void'(model.pop_front());
            if (m_enq) model.push_back(in_msg);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_count", 32'(qif.io_count), 32'(model.size()));
            chk("cmp_in_ready", 32'(qif.io_in_ready), 32'(model.size() < DEPTH));
            if (model.size() > 0) begin
                chk("cmp_valid", 32'(dut_valid()), 32'(4'b0001 << model[0][29:28]));
                chk("cmp_bits", dut_bits(), model[0]);
            end else begin
                chk("cmp_valid_empty", 32'(dut_valid()), 32'd0);
            end
        end
    end

    // Drive one cycle of inputs, return just after the following falling edge.
    task automatic cyc(input logic v, input logic [31:0] m, input logic [3:0] r);
        in_valid  = v;
        in_msg    = m;
        out_ready = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [31:0] msgs [10];

    initial begin
        for (int i = 0; i < 10; i++)
            msgs[i] = mk(2'(i), 2'(i % 4), 26'(32'h100 + i * 32'h11), 2'(i + 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(qif.io_count), 32'd0);
        chk("rst_in_ready", 32'(qif.io_in_ready), 32'd1);
        chk("rst_valid", 32'(dut_valid()), 32'd0);
        reset = 1'b0;
        #1;

        // Single message to port 2, visible one cycle after acceptance.
        cyc(1'b1, mk(2'd1, 2'd2, 26'h0000ABC, 2'd1), 4'b0100);
        chk("lat_valid", 32'(dut_valid()), 32'h4);
        chk("lat_addr", 32'(qif.io_out_bits_payload_addr_block), 32'h0000ABC);
        chk("lat_ptype", 32'(qif.io_out_bits_payload_p_type), 32'd1);
        cyc(1'b0, '0, 4'b0100);
        chk("lat_drained", 32'(qif.io_count), 32'd0);

        // Fill with all readies low; fifth offer refused.
        for (int i = 0; i < 5; i++) cyc(1'b1, msgs[i], 4'b0000);
        chk("full_count", 32'(qif.io_count), 32'd4);
        chk("full_in_ready", 32'(qif.io_in_ready), 32'd0);
        chk("full_head", dut_bits(), msgs[0]);
        cyc(1'b1, msgs[4], 4'b1111);
        chk("first_deq_count", 32'(qif.io_count), 32'd3);
        chk("first_deq_ready", 32'(qif.io_in_ready), 32'd1);
        chk("first_deq_head", dut_bits(), msgs[1]);
        cyc(1'b1, msgs[4], 4'b1111);
        chk("fifth_acc_count", 32'(qif.io_count), 32'd3);
        chk("fifth_acc_head", dut_bits(), msgs[2]);
        repeat (3) cyc(1'b0, '0, 4'b1111);
        chk("fill_drained", 32'(qif.io_count), 32'd0);

        // Full plus simultaneous offer/dequeue: offer refused, then both happen.
        for (int i = 5; i < 9; i++) cyc(1'b1, msgs[i], 4'b0000);
        cyc(1'b1, msgs[9], 4'b1111);
        chk("fulldeq_count", 32'(qif.io_count), 32'd3);
        chk("fulldeq_ready", 32'(qif.io_in_ready), 32'd1);
        cyc(1'b1, msgs[9], 4'b1111);
        chk("both_count", 32'(qif.io_count), 32'd3);
        chk("both_head", dut_bits(), msgs[7]);
        repeat (3) cyc(1'b0, '0, 4'b1111);
        chk("both_drained", 32'(qif.io_count), 32'd0);

        // Head to port 3 stalls; entry behind it for port 0 must wait.
        cyc(1'b1, mk(2'd0, 2'd3, 26'h3333, 2'd2), 4'b0111);
        cyc(1'b1, mk(2'd1, 2'd0, 26'h0000, 2'd3), 4'b0111);
        repeat (2) begin
            cyc(1'b0, '0, 4'b0111);
            chk("hol_valid", 32'(dut_valid()), 32'h8);
            chk("hol_count", 32'(qif.io_count), 32'd2);
        end
        cyc(1'b0, '0, 4'b1000);
        chk("hol_released", 32'(dut_valid()), 32'h1);
        chk("hol_rel_count", 32'(qif.io_count), 32'd1);
        cyc(1'b0, '0, 4'b0001);
        chk("hol_drained", 32'(qif.io_count), 32'd0);

        // Ten back-to-back enqueue+dequeue cycles wrap both pointers.
        cyc(1'b1, msgs[0], 4'b1111);
        for (int i = 1; i < 10; i++) begin
            cyc(1'b1, msgs[i], 4'b1111);
            chk("wrap_count", 32'(qif.io_count), 32'd1);
            chk("wrap_head", dut_bits(), msgs[i]);
        end
        cyc(1'b1, msgs[3], 4'b1111);
        chk("wrap_tenth", dut_bits(), msgs[3]);
        cyc(1'b0, '0, 4'b1111);
        chk("wrap_drained", 32'(qif.io_count), 32'd0);

        // Reset with three queued, observed before any clock edge.
        for (int i = 0; i < 3; i++) cyc(1'b1, msgs[i], 4'b0000);
        chk("pre_rst_count", 32'(qif.io_count), 32'd3);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("async_rst_count", 32'(qif.io_count), 32'd0);
        chk("async_rst_ready", 32'(qif.io_in_ready), 32'd1);
        chk("async_rst_valid", 32'(dut_valid()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, msgs[6], 4'b0000);
        chk("post_rst_count", 32'(qif.io_count), 32'd1);
        chk("post_rst_head", dut_bits(), msgs[6]);
        cyc(1'b0, '0, 4'b1111);
        chk("post_rst_drained", 32'(qif.io_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
